// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that maps per-thread LSU read/write requests onto a
// small pool of data-memory channels and relays data/completion back.
module data_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);
  // state          | meaning
  // IDLE           | channel free, arbitrates this cycle
  // READ_WAITING   | mem_read_valid high until mem_read_ready
  // WRITE_WAITING  | mem_write_valid high until mem_write_ready
  // READ_RELAYING  | consumer_read_ready high until read_valid drops
  // WRITE_RELAYING | consumer_write_ready high until write_valid drops
  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
  } state_e;

  state_e               state_q [NUM_CHANNELS];
  state_e               state_d [NUM_CHANNELS];
  logic [CW-1:0]        cur_q   [NUM_CHANNELS];
  logic [CW-1:0]        cur_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] mra_q   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] mra_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] mwa_q   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] mwa_d   [NUM_CHANNELS];
  logic [DATA_BITS-1:0] mwd_q   [NUM_CHANNELS];
  logic [DATA_BITS-1:0] mwd_d   [NUM_CHANNELS];
  logic [DATA_BITS-1:0] m_rdata [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mrv_q, mrv_d, mwv_q, mwv_d;

  logic [ADDR_BITS-1:0] c_raddr   [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0] c_waddr   [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] c_wdata   [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rd_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rd_data_d [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] claimed_q, claimed_d;
  logic [NUM_CONSUMERS-1:0] rd_ready_q, rd_ready_d, wr_ready_q, wr_ready_d;
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_CONSUMERS-1:0] taken;
  logic                     any_grant;
  logic                     found;
  logic [CW-1:0]            hi_idx;
  logic [CW-1:0]            idx;

  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_cons
    assign c_raddr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign c_waddr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign c_wdata[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = rd_data_q[g];
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    assign m_rdata[g] = mem_read_data[g*DATA_BITS +: DATA_BITS];
    assign mem_read_address[g*ADDR_BITS +: ADDR_BITS]  = mra_q[g];
    assign mem_write_address[g*ADDR_BITS +: ADDR_BITS] = mwa_q[g];
    assign mem_write_data[g*DATA_BITS +: DATA_BITS]    = mwd_q[g];
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_write_ready = wr_ready_q;
  assign mem_read_valid       = mrv_q;
  assign mem_write_valid      = mwv_q;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    mra_d      = mra_q;
    mwa_d      = mwa_q;
    mwd_d      = mwd_q;
    mrv_d      = mrv_q;
    mwv_d      = mwv_q;
    rd_data_d  = rd_data_q;
    claimed_d  = claimed_q;
    rd_ready_d = rd_ready_q;
    wr_ready_d = wr_ready_q;
    rr_ptr_d   = rr_ptr_q;
    taken      = '0;
    any_grant  = 1'b0;
    found      = 1'b0;
    hi_idx     = '0;
    idx        = '0;
    // Channels resolve in ascending order so lower channels win contested consumers.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      case (state_q[c])
        IDLE: begin
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            idx = CW'((int'(rr_ptr_q) + i) % NUM_CONSUMERS);
            if (!found && (consumer_read_valid[idx] || consumer_write_valid[idx]) &&
                !claimed_q[idx] && !taken[idx]) begin
              found          = 1'b1;
              taken[idx]     = 1'b1;
              claimed_d[idx] = 1'b1;
              cur_d[c]       = idx;
              if (!any_grant || idx > hi_idx) hi_idx = idx;
              any_grant = 1'b1;
              if (consumer_read_valid[idx]) begin
                state_d[c] = READ_WAITING;
                mrv_d[c]   = 1'b1;
                mra_d[c]   = c_raddr[idx];
              end else begin
                state_d[c] = WRITE_WAITING;
                mwv_d[c]   = 1'b1;
                mwa_d[c]   = c_waddr[idx];
                mwd_d[c]   = c_wdata[idx];
              end
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[c]) begin
            mrv_d[c]              = 1'b0;
            rd_data_d[cur_q[c]]   = m_rdata[c];
            rd_ready_d[cur_q[c]]  = 1'b1;
            state_d[c]            = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[c]) begin
            mwv_d[c]             = 1'b0;
            wr_ready_d[cur_q[c]] = 1'b1;
            state_d[c]           = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[cur_q[c]]) begin
            rd_ready_d[cur_q[c]] = 1'b0;
            claimed_d[cur_q[c]]  = 1'b0;
            state_d[c]           = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[cur_q[c]]) begin
            wr_ready_d[cur_q[c]] = 1'b0;
            claimed_d[cur_q[c]]  = 1'b0;
            state_d[c]           = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
    if (any_grant) rr_ptr_d = CW'((int'(hi_idx) + 1) % NUM_CONSUMERS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cur_q[c]   <= '0;
        mra_q[c]   <= '0;
        mwa_q[c]   <= '0;
        mwd_q[c]   <= '0;
      end
      for (int i = 0; i < NUM_CONSUMERS; i++) rd_data_q[i] <= '0;
      mrv_q      <= '0;
      mwv_q      <= '0;
      claimed_q  <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      mra_q      <= mra_d;
      mwa_q      <= mwa_d;
      mwd_q      <= mwd_d;
      rd_data_q  <= rd_data_d;
      mrv_q      <= mrv_d;
      mwv_q      <= mwv_d;
      claimed_q  <= claimed_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and randomized bench for data_mem_arbiter, checked every cycle
// against a transaction-level model of channel ownership.
module tb_data_mem_arbiter;
  localparam int NC  = 4;
  localparam int NCH = 2;
  localparam int AB  = 8;
  localparam int DB  = 16;

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0]  rv, wv;
  logic [AB-1:0]  raddr [NC];
  logic [AB-1:0]  waddr [NC];
  logic [DB-1:0]  wdata [NC];
  logic [NCH-1:0] mrr, mwr;
  logic [DB-1:0]  mem_rom [256];

  logic [NC*AB-1:0]  raddr_flat, waddr_flat;
  logic [NC*DB-1:0]  wdata_flat, consumer_read_data;
  logic [NC-1:0]     consumer_read_ready, consumer_write_ready;
  logic [NCH-1:0]    mem_read_valid, mem_write_valid;
  logic [NCH*AB-1:0] mem_read_address, mem_write_address;
  logic [NCH*DB-1:0] mem_read_data, mem_write_data;
  logic              any_out;

  for (genvar g = 0; g < NC; g++) begin : g_pack
    assign raddr_flat[g*AB +: AB] = raddr[g];
    assign waddr_flat[g*AB +: AB] = waddr[g];
    assign wdata_flat[g*DB +: DB] = wdata[g];
  end
  assign mem_read_data = {mem_rom[mem_read_address[15:8]], mem_rom[mem_read_address[7:0]]};
  assign any_out = |{consumer_read_ready, consumer_read_data, consumer_write_ready,
                     mem_read_valid, mem_read_address, mem_write_valid,
                     mem_write_address, mem_write_data};

  data_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(raddr_flat),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(wv), .consumer_write_address(waddr_flat),
    .consumer_write_data(wdata_flat), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mrr), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mwr)
  );

  always #5 clk = ~clk;

  // Model: which consumer owns each channel, and whether memory has answered yet.
  int          ch_owner [NCH];
  bit          ch_write [NCH];
  bit          ch_done  [NCH];
  logic [AB-1:0] m_raddr [NCH];
  logic [AB-1:0] m_waddr [NCH];
  logic [DB-1:0] m_wdata [NCH];
  bit          e_rready [NC];
  bit          e_wready [NC];
  logic [DB-1:0] e_rdata [NC];
  int          rr;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit claimed(input int i);
    for (int c = 0; c < NCH; c++) if (ch_owner[c] == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      ch_owner[c] = -1; ch_write[c] = 1'b0; ch_done[c] = 1'b0;
      m_raddr[c] = '0; m_waddr[c] = '0; m_wdata[c] = '0;
    end
    for (int i = 0; i < NC; i++) begin
      e_rready[i] = 1'b0; e_wready[i] = 1'b0; e_rdata[i] = '0;
    end
    rr = 0;
  endtask

  task automatic model_step();
    bit busy [NC];
    bit was_idle [NCH];
    bit taken [NC];
    int hi, o, cand;
    for (int i = 0; i < NC; i++) begin busy[i] = claimed(i); taken[i] = 1'b0; end
    for (int c = 0; c < NCH; c++) was_idle[c] = (ch_owner[c] < 0);
    for (int c = 0; c < NCH; c++) begin
      if (!was_idle[c]) begin
        o = ch_owner[c];
        if (!ch_done[c]) begin
          if (ch_write[c] ? mwr[c] : mrr[c]) begin
            ch_done[c] = 1'b1;
            if (ch_write[c]) e_wready[o] = 1'b1;
            else begin e_rready[o] = 1'b1; e_rdata[o] = mem_rom[m_raddr[c]]; end
          end
        end else if (ch_write[c] ? !wv[o] : !rv[o]) begin
          if (ch_write[c]) e_wready[o] = 1'b0; else e_rready[o] = 1'b0;
          ch_owner[c] = -1;
        end
      end
    end
    hi = -1;
    for (int c = 0; c < NCH; c++) begin
      if (was_idle[c]) begin
        for (int k = 0; k < NC; k++) begin
          cand = (rr + k) % NC;
          if ((rv[cand] || wv[cand]) && !busy[cand] && !taken[cand]) begin
            taken[cand] = 1'b1;
            ch_owner[c] = cand; ch_done[c] = 1'b0; ch_write[c] = !rv[cand];
            if (rv[cand]) m_raddr[c] = raddr[cand];
            else begin m_waddr[c] = waddr[cand]; m_wdata[c] = wdata[cand]; end
            if (cand > hi) hi = cand;
            break;
          end
        end
      end
    end
    if (hi >= 0) rr = (hi + 1) % NC;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("rready[%0d]", i), 32'(consumer_read_ready[i]), 32'(e_rready[i]));
      chk($sformatf("wready[%0d]", i), 32'(consumer_write_ready[i]), 32'(e_wready[i]));
      chk($sformatf("rdata[%0d]", i), 32'(consumer_read_data[i*DB +: DB]), 32'(e_rdata[i]));
    end
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("mem_rvalid[%0d]", c), 32'(mem_read_valid[c]),
          32'(ch_owner[c] >= 0 && !ch_done[c] && !ch_write[c]));
      chk($sformatf("mem_wvalid[%0d]", c), 32'(mem_write_valid[c]),
          32'(ch_owner[c] >= 0 && !ch_done[c] && ch_write[c]));
      chk($sformatf("mem_raddr[%0d]", c), 32'(mem_read_address[c*AB +: AB]), 32'(m_raddr[c]));
      chk($sformatf("mem_waddr[%0d]", c), 32'(mem_write_address[c*AB +: AB]), 32'(m_waddr[c]));
      chk($sformatf("mem_wdata[%0d]", c), 32'(mem_write_data[c*DB +: DB]), 32'(m_wdata[c]));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NC; i++) begin
        if (e_rready[i]) rv[i] = 1'b0;
        if (e_wready[i]) wv[i] = 1'b0;
      end
      cycle();
    end
  endtask

  initial begin
    int cnt, rd_at, wr_at;
    bit done;
    logic [1:0] r;
    reset = 1'b0; rv = '0; wv = '0; mrr = '0; mwr = '0;
    for (int i = 0; i < NC; i++) begin raddr[i] = '0; waddr[i] = '0; wdata[i] = '0; end
    for (int a = 0; a < 256; a++) mem_rom[a] = 16'($urandom);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", 32'(any_out), 0);
    reset = 1'b1;

    // Reset while a read is waiting on memory.
    rv[2] = 1'b1; raddr[2] = 8'h60; mrr = '0;
    cycle();
    chk("rst_read_inflight", 32'(mem_read_valid[0]), 1);
    reset = 1'b0;
    #1;
    chk("rst_async_zero", 32'(any_out), 0);
    rv = '0; model_reset();
    @(posedge clk); @(negedge clk);
    chk("rst_hold_zero", 32'(any_out), 0);
    reset = 1'b1;
    mem_rom[8'h10] = 16'hBEEF; rv[3] = 1'b1; raddr[3] = 8'h10; mrr = '1; mwr = '1;
    cycle();
    chk("rst_fresh_addr", 32'(mem_read_address[7:0]), 32'h10);
    cycle();
    chk("rst_fresh_ready", 32'(consumer_read_ready[3]), 1);
    chk("rst_fresh_data", 32'(consumer_read_data[3*DB +: DB]), 32'hBEEF);
    settle(3);

    // Four simultaneous reads on two channels.
    for (int i = 0; i < NC; i++) begin rv[i] = 1'b1; raddr[i] = 8'(8'h30 + i); end
    cycle();
    chk("all4_first_valid", 32'(mem_read_valid), 32'h3);
    chk("all4_first_ch0", 32'(mem_read_address[7:0]), 32'h30);
    chk("all4_first_ch1", 32'(mem_read_address[15:8]), 32'h31);
    settle(3);
    chk("all4_second_valid", 32'(mem_read_valid), 32'h3);
    chk("all4_second_ch0", 32'(mem_read_address[7:0]), 32'h32);
    chk("all4_second_ch1", 32'(mem_read_address[15:8]), 32'h33);
    settle(4);

    // Single zero-wait read.
    mem_rom[8'h05] = 16'h4000; rv[2] = 1'b1; raddr[2] = 8'h05;
    cycle();
    chk("single_mem_valid", 32'(mem_read_valid[0]), 1);
    chk("single_mem_addr", 32'(mem_read_address[7:0]), 32'h05);
    cycle();
    chk("single_ready", 32'(consumer_read_ready[2]), 1);
    chk("single_data", 32'(consumer_read_data[2*DB +: DB]), 32'h4000);
    settle(3);

    // Write with a 3-cycle memory wait; consumer address/data scrambled after grant.
    mwr = '0; wv[1] = 1'b1; waddr[1] = 8'h22; wdata[1] = 16'h8001;
    cnt = 0; done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      cycle();
      waddr[1] = 8'($urandom); wdata[1] = 16'($urandom);
      if (mem_write_valid[0]) begin
        cnt++;
        chk("wait_wr_addr", 32'(mem_write_address[7:0]), 32'h22);
        chk("wait_wr_data", 32'(mem_write_data[15:0]), 32'h8001);
      end
      if (cnt == 4) mwr[0] = 1'b1;
      if (consumer_write_ready[1]) done = 1'b1;
    end
    chk("wait_wr_valid_cycles", 32'(cnt), 4);
    chk("wait_wr_ready", 32'(done), 1);
    mwr = '1;
    settle(3);

    // Read and write from the same consumer: read first, write after release.
    rv[3] = 1'b1; wv[3] = 1'b1; raddr[3] = 8'h44; waddr[3] = 8'h45; wdata[3] = 16'h1111;
    rd_at = -1; wr_at = -1;
    for (int k = 0; k < 16; k++) begin
      settle(1);
      for (int c = 0; c < NCH; c++) begin
        if (mem_read_valid[c] && mem_read_address[c*AB +: AB] == 8'h44 && rd_at < 0) rd_at = k;
        if (mem_write_valid[c] && mem_write_address[c*AB +: AB] == 8'h45 && wr_at < 0) wr_at = k;
      end
    end
    chk("rw_read_seen", 32'(rd_at >= 0), 1);
    chk("rw_write_gap", 32'(wr_at - rd_at), 3);

    // Consumer 0 abandons a read during a 2-cycle memory wait.
    mrr = '0; rv[0] = 1'b1; raddr[0] = 8'h50;
    cycle();
    chk("drop_grant", 32'(mem_read_valid[0]), 1);
    rv[0] = 1'b0;
    cycle(); cycle();
    mrr = '1;
    cycle();
    chk("drop_ready_pulse", 32'(consumer_read_ready[0]), 1);
    cycle();
    chk("drop_ready_gone", 32'(consumer_read_ready[0]), 0);
    rv[1] = 1'b1; raddr[1] = 8'h51;
    cycle();
    chk("drop_next_valid", 32'(mem_read_valid[0]), 1);
    chk("drop_next_addr", 32'(mem_read_address[7:0]), 32'h51);
    settle(6);

    // Randomized traffic with random memory stalls and early drops.
    for (int n = 0; n < 3000; n++) begin
      mrr = 2'($urandom); mwr = 2'($urandom);
      for (int i = 0; i < NC; i++) begin
        raddr[i] = 8'($urandom); waddr[i] = 8'($urandom); wdata[i] = 16'($urandom);
        if (rv[i] && e_rready[i] && $urandom_range(0, 2) != 0) rv[i] = 1'b0;
        if (wv[i] && e_wready[i] && $urandom_range(0, 2) != 0) wv[i] = 1'b0;
        if (rv[i] && !e_rready[i] && $urandom_range(0, 49) == 0) rv[i] = 1'b0;
        if (!rv[i] && !wv[i] && !claimed(i) && $urandom_range(0, 2) == 0) begin
          r = 2'($urandom_range(1, 3));
          rv[i] = r[0]; wv[i] = r[1];
        end
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
